// File: rtl/keypad_scan_fifo_if.sv
// Key-event stream from the keypad scanner: FIFO head code with valid/ready handshake.
interface keypad_scan_fifo_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// ROWS x COLS matrix-keypad scanner: divider tick, row synchroniser, press/release
// debounce FSM and a key-event FIFO with registered valid/ready head.
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 131072,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROWS-1:0]     row,
    output logic [COLS-1:0]     col,
    keypad_scan_fifo_if.master  key,
    output logic                key_held,
    output logic                overflow,
    input  logic                ovf_clr
);
    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE+1);
    localparam int AW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEB, S_PRESSED} state_t;

    state_t             state, state_n;
    logic [ROWS-1:0]    row_s1, row_s2;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick, hit, found;
    logic [RW-1:0]      r_lo, lat_r, r_n;
    logic [CW-1:0]      c, c_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [COLS-1:0]    col_n;
    logic               push;
    logic [CODE_W-1:0]  push_code;

    function automatic logic [CODE_W-1:0] code_of(input logic [RW-1:0] r, input logic [CW-1:0] cc);
        return CODE_W'(int'(r) * COLS + int'(cc));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1  <= '1;
            row_s2  <= '1;
            div_cnt <= '0;
        end else begin
            row_s1  <= row;
            row_s2  <= row_s1;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_W'(SCAN_DIV-1));
    assign hit  = (row_s2 != '1);

    always_comb begin
        r_lo  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (!found && !row_s2[i]) begin
                r_lo  = RW'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            c     <= '0;
            lat_r <= '0;
            cnt   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            c     <= c_n;
            lat_r <= r_n;
            cnt   <= cnt_n;
            col   <= col_n;
        end
    end

    always_comb begin
        state_n   = state;
        c_n       = c;
        r_n       = lat_r;
        cnt_n     = cnt;
        col_n     = col;
        push      = 1'b0;
        push_code = '0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    col_n = '0;
                    if (hit) begin
                        state_n = S_SCAN;
                        c_n     = '0;
                        col_n   = ~(COLS'(1));
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        r_n   = r_lo;
                        cnt_n = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            push      = 1'b1;
                            push_code = code_of(r_lo, c);
                            cnt_n     = '0;
                            state_n   = S_PRESSED;
                        end else begin
                            state_n = S_DEB;
                        end
                    end else if (c < CW'(COLS-1)) begin
                        c_n   = c + 1'b1;
                        col_n = ~(COLS'(1) << (c + 1'b1));
                    end else begin
                        state_n = S_IDLE;
                        col_n   = '0;
                    end
                end
                S_DEB: begin
                    if (!row_s2[lat_r]) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CNT_W'(DEBOUNCE)) begin
                            push      = 1'b1;
                            push_code = code_of(lat_r, c);
                            cnt_n     = '0;
                            state_n   = S_PRESSED;
                        end
                    end else begin
                        state_n = S_IDLE;
                        col_n   = '0;
                        cnt_n   = '0;
                    end
                end
                S_PRESSED: begin
                    if (!hit) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CNT_W'(DEBOUNCE)) begin
                            state_n = S_IDLE;
                            col_n   = '0;
                            cnt_n   = '0;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        key_held = (state == S_PRESSED);
    end

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_n;
    logic [AW:0]       count, count_n, remaining;
    logic              full, pop, push_ok, drop;
    logic [CODE_W-1:0] head_n;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = key.key_valid & key.key_ready;
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign count_n   = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    assign rd_n      = rd_ptr + AW'(pop);
    assign remaining = count - (AW+1)'(pop);
    // The slot at rd_n is only written this cycle when the FIFO drains empty, so forward the push.
    assign head_n    = (push_ok && remaining == '0) ? push_code : mem[rd_n];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            key.key_valid <= 1'b0;
            key.key_code  <= '0;
            overflow      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr        <= rd_n;
            count         <= count_n;
            key.key_valid <= (count_n != '0);
            key.key_code  <= head_n;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a 4x4 switch-matrix model (key index = row*4+col).
module tb_keypad_scan_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_held, overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] keys = '0;
    int unsigned cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  got[$];
    logic [3:0]  g;

    keypad_scan_fifo_if #(.CODE_W(4)) kif ();

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key(kif),
        .key_held(key_held), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            row[r] = 1'b1;
            for (int unsigned c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && kif.key_valid && kif.key_ready) got.push_back(kif.key_code);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_release(input int idx);
        keys[idx] = 1'b1;
        step(40);
        keys = '0;
        step(32);
    endtask

    task automatic test_reset;
        n_cmp++; if (col !== 4'b0000) begin n_err++; $display("FAIL reset_col got=%b exp=0000", col); end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", kif.key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held got=%b exp=0", key_held); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_cmp++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL reset_code got=%0d exp=0", kif.key_code); end
    endtask

    task automatic test_single_press;
        got.delete();
        kif.key_ready = 1'b1;
        keys[9] = 1'b1;
        step(160);
        n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL single_count got=%0d exp=1", got.size()); end
        g = (got.size() > 0) ? got[0] : 4'bxxxx;
        n_cmp++; if (g !== 4'd9) begin n_err++; $display("FAIL single_code got=%0d exp=9", g); end
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL single_held got=%b exp=1", key_held); end
        keys = '0;
        step(8);
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL release_early_held got=%b exp=1", key_held); end
        step(16);
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL release_held got=%b exp=0", key_held); end
        n_cmp++; if (col !== 4'b0000) begin n_err++; $display("FAIL release_col got=%b exp=0000", col); end
        n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL single_total got=%0d exp=1", got.size()); end
    endtask

    task automatic test_glitch;
        got.delete();
        keys[0] = 1'b1;
        step(8);
        keys = '0;
        step(40);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL glitch_events got=%0d exp=0", got.size()); end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid got=%b exp=0", kif.key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL glitch_held got=%b exp=0", key_held); end
        n_cmp++; if (col !== 4'b0000) begin n_err++; $display("FAIL glitch_col got=%b exp=0000", col); end
    endtask

    task automatic test_overflow;
        logic [3:0] exp_q[4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        got.delete();
        kif.key_ready = 1'b0;
        press_release(0);
        press_release(5);
        press_release(10);
        press_release(15);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got=%b exp=0", overflow); end
        n_cmp++; if (kif.key_code !== 4'd0) begin n_err++; $display("FAIL full_head got=%0d exp=0", kif.key_code); end
        press_release(3);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        kif.key_ready = 1'b1;
        step(10);
        n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL drain_count got=%0d exp=4", got.size()); end
        for (int unsigned i = 0; i < 4; i++) begin
            g = (got.size() > i) ? got[i] : 4'bxxxx;
            n_cmp++; if (g !== exp_q[i]) begin n_err++; $display("FAIL drain_code[%0d] got=%0d exp=%0d", i, g, exp_q[i]); end
        end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%b exp=0", kif.key_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  exp_q[5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd12};
        int unsigned t0;
        got.delete();
        kif.key_ready = 1'b0;
        press_release(1);
        press_release(2);
        press_release(4);
        press_release(8);
        do step(1); while (cyc % 4 != 0);
        t0 = cyc;
        keys[12] = 1'b1;
        // Key in column 0 is detected 4 clk later and pushed 3 ticks after that.
        while (cyc < t0 + 15) step(1);
        kif.key_ready = 1'b1;
        step(1);
        kif.key_ready = 1'b0;
        step(1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
        n_cmp++; if (kif.key_code !== 4'd2) begin n_err++; $display("FAIL b2b_head got=%0d exp=2", kif.key_code); end
        keys = '0;
        step(32);
        kif.key_ready = 1'b1;
        step(10);
        n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL b2b_count got=%0d exp=5", got.size()); end
        for (int unsigned i = 0; i < 5; i++) begin
            g = (got.size() > i) ? got[i] : 4'bxxxx;
            n_cmp++; if (g !== exp_q[i]) begin n_err++; $display("FAIL b2b_code[%0d] got=%0d exp=%0d", i, g, exp_q[i]); end
        end
    endtask

    task automatic test_multi_row;
        got.delete();
        kif.key_ready = 1'b1;
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        step(40);
        n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL multi_count got=%0d exp=1", got.size()); end
        g = (got.size() > 0) ? got[0] : 4'bxxxx;
        n_cmp++; if (g !== 4'd6) begin n_err++; $display("FAIL multi_code got=%0d exp=6", g); end
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL multi_held got=%b exp=1", key_held); end
        keys = '0;
        step(32);
    endtask

    task automatic test_reset_mid;
        got.delete();
        kif.key_ready = 1'b0;
        press_release(7);
        press_release(11);
        keys[13] = 1'b1;
        step(40);
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL pre_rst_held got=%b exp=1", key_held); end
        n_cmp++; if (kif.key_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid got=%b exp=1", kif.key_valid); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", kif.key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rst_held got=%b exp=0", key_held); end
        n_cmp++; if (col !== 4'b0000) begin n_err++; $display("FAIL rst_col got=%b exp=0000", col); end
        keys = '0;
        step(2);
        rst = 1'b0;
        kif.key_ready = 1'b1;
        step(60);
        n_cmp++; if (got.size() !== 0) begin n_err++; $display("FAIL stale_events got=%0d exp=0", got.size()); end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_valid got=%b exp=0", kif.key_valid); end
    endtask

    initial begin
        kif.key_ready = 1'b0;
        #12;
        test_reset;
        #11 rst = 1'b0;
        step(2);
        test_reset;
        test_single_press;
        test_glitch;
        test_overflow;
        test_back_to_back;
        test_multi_row;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
